// File: rtl/ex_muldiv_ctrl.sv
// ============================================================================
// ex_muldiv_ctrl
// ----------------------------------------------------------------------------
// Execute-stage scheduler for the RV32M multiply/divide instructions.
//
// When the IDEX instruction is an M-extension op, the block latches the
// operand magnitudes and the result sign. It then runs an iterative radix-2
// engine: one shift-add step per cycle for multiplies, or one restoring
// subtract-shift step per cycle for divides. While the engine runs, the
// pipeline front end is stalled. The finished result is presented for one
// advance cycle, or for longer while the memory stage holds the pipe.
//
// Divide-by-zero and signed overflow skip the engine entirely. Their
// architecturally defined results are preloaded, and the block goes straight
// to DONE.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   IDEX_MdEn  in   IDEX instruction is MUL/DIV/REM class
//   IDEX_MdOp  in   funct3 of the M op (0 MUL .. 7 REMU)
//   s1, s2     in   operands after forwarding/select mux
//   EX_Flush   in   kill the EX instruction
//   Mem_Hold   in   downstream stall, EX may not advance
//   MD_Stall   out  hold PC/IFID/IDEX (combinational in the issue cycle)
//   MD_Valid   out  MD_Result is valid this cycle
//   MD_Result  out  registered multiply/divide result
//   MD_Busy    out  engine is not idle
// ============================================================================
module ex_muldiv_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            IDEX_MdEn,
   input  logic [2:0]      IDEX_MdOp,
   input  logic [XLEN-1:0] s1,
   input  logic [XLEN-1:0] s2,
   input  logic            EX_Flush,
   input  logic            Mem_Hold,
   output logic            MD_Stall,
   output logic            MD_Valid,
   output logic [XLEN-1:0] MD_Result,
   output logic            MD_Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [XLEN-1:0]     opnd_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     result_q;
   logic                valid_q;
   logic                busy_q;

   // ----------------------------------------------------------------------
   // Issue-cycle decode.
   // Works out which operands are treated as signed and takes their
   // magnitudes. It also derives the result sign and detects the two
   // special divide cases that bypass the engine.
   // ----------------------------------------------------------------------
   logic            is_div;
   logic            s1_signed;
   logic            s2_signed;
   logic            s1_neg;
   logic            s2_neg;
   logic [XLEN-1:0] s1_mag;
   logic [XLEN-1:0] s2_mag;
   logic            res_neg;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] fast_result;

   always_comb begin
      is_div    = IDEX_MdOp[2];
      s1_signed = (IDEX_MdOp == OP_MUL) || (IDEX_MdOp == OP_MULH) ||
                  (IDEX_MdOp == OP_MULHSU) || (IDEX_MdOp == OP_DIV) ||
                  (IDEX_MdOp == OP_REM);
      s2_signed = (IDEX_MdOp == OP_MUL) || (IDEX_MdOp == OP_MULH) ||
                  (IDEX_MdOp == OP_DIV) || (IDEX_MdOp == OP_REM);
      s1_neg    = s1_signed & s1[XLEN-1];
      s2_neg    = s2_signed & s2[XLEN-1];
      s1_mag    = s1_neg ? -s1 : s1;
      s2_mag    = s2_neg ? -s2 : s2;
      // A remainder takes the sign of the dividend.
      // Quotients and products take the XOR of the two operand signs.
      res_neg   = (is_div & IDEX_MdOp[1]) ? s1_neg : (s1_neg ^ s2_neg);
      div_zero  = is_div & (s2 == '0);
      div_ovf   = is_div & ~IDEX_MdOp[0] & (s1 == INT_MIN) & (s2 == '1);
      fast_result = '0;
      if (div_zero) begin
         fast_result = IDEX_MdOp[1] ? s1 : '1;
      end else if (div_ovf) begin
         fast_result = IDEX_MdOp[1] ? '0 : INT_MIN;
      end
   end

   // ----------------------------------------------------------------------
   // One engine step, computed from the current accumulator.
   //
   // Multiply: the low half starts as the multiplier, and the high half
   // collects partial sums. Each step conditionally adds the multiplicand
   // to the high half and shifts the 65-bit value right by one.
   //
   // Divide: the high half is the partial remainder, and the low half
   // starts as the dividend and fills with quotient bits. Each step shifts
   // left by one and subtracts the divisor if it fits.
   //
   // The final result is taken from the post-step value, so it can be
   // registered on the same edge that enters DONE.
   // ----------------------------------------------------------------------
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   div_sel;
   logic [XLEN-1:0]   final_result;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_q})
                         : div_shift[XLEN-1:0];
      div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
      acc_next  = op_q[2] ? div_next : mul_next;

      prod_fixed = neg_q ? -acc_next : acc_next;
      div_sel    = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      if (op_q[2]) begin
         final_result = neg_q ? -div_sel : div_sel;
      end else if (op_q == OP_MUL) begin
         final_result = prod_fixed[XLEN-1:0];
      end else begin
         final_result = prod_fixed[2*XLEN-1:XLEN];
      end
   end

   // ----------------------------------------------------------------------
   // Control FSM.
   // A flush always wins and returns the FSM to IDLE. In DONE the result
   // stays put until the memory stage lets the instruction advance.
   // ----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (IDEX_MdEn && !EX_Flush) begin
                  op_q   <= IDEX_MdOp;
                  neg_q  <= res_neg;
                  count  <= '0;
                  busy_q <= 1'b1;
                  if (is_div) begin
                     opnd_q <= s2_mag;
                     acc_q  <= {{XLEN{1'b0}}, s1_mag};
                  end else begin
                     opnd_q <= s1_mag;
                     acc_q  <= {{XLEN{1'b0}}, s2_mag};
                  end
                  if (div_zero || div_ovf) begin
                     state    <= DONE;
                     result_q <= fast_result;
                     valid_q  <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (EX_Flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  acc_q <= acc_next;
                  count <= count + 1'b1;
                  if (count == CNT_W'(XLEN-1)) begin
                     state    <= DONE;
                     result_q <= final_result;
                     valid_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (EX_Flush || !Mem_Hold) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The stall has to be raised in the issue cycle itself, before any state
   // has changed, so it is decoded directly from the inputs. A flush drops
   // the stall immediately.
   always_comb begin
      MD_Stall = ~EX_Flush &
                 (((state == IDLE) & IDEX_MdEn) | (state == CALC));
   end

   assign MD_Valid  = valid_q;
   assign MD_Result = result_q;
   assign MD_Busy   = busy_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ============================================================================
// tb_ex_muldiv_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for ex_muldiv_ctrl. Expected results come from a
// behavioural model that uses plain 64-bit signed/unsigned arithmetic and
// the RV32M special-case rules. Expected latency comes from the rule
// "1 cycle for the divide special cases, otherwise 33".
// ============================================================================
module tb_ex_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        IDEX_MdEn;
   logic [2:0]  IDEX_MdOp;
   logic [31:0] s1;
   logic [31:0] s2;
   logic        EX_Flush;
   logic        Mem_Hold;
   logic        MD_Stall;
   logic        MD_Valid;
   logic [31:0] MD_Result;
   logic        MD_Busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .IDEX_MdEn (IDEX_MdEn),
      .IDEX_MdOp (IDEX_MdOp),
      .s1        (s1),
      .s2        (s2),
      .EX_Flush  (EX_Flush),
      .Mem_Hold  (Mem_Hold),
      .MD_Stall  (MD_Stall),
      .MD_Valid  (MD_Valid),
      .MD_Result (MD_Result),
      .MD_Busy   (MD_Busy)
   );

   // Reference result using 64-bit arithmetic and the RV32M rules.
   function automatic logic [31:0] ref_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (op)
         3'd0: begin p = 64'(sa * sb); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Reference latency: the number of cycles from issue until MD_Valid.
   function automatic int ref_latency(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      if (op >= 3'd4 && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
          b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issues one op and tracks the stall and the latency. Then it holds DONE
   // for 'hold' extra cycles with Mem_Hold and checks the result throughout.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int hold, input string tag);
      int lat_exp;
      int lat;
      int stall_bad;
      lat_exp = ref_latency(op, a, b);
      @(negedge clk);
      IDEX_MdEn = 1'b1;
      IDEX_MdOp = op;
      s1        = a;
      s2        = b;
      Mem_Hold  = (hold > 0);
      #1;
      checks++;
      if (MD_Stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s issue_stall: got %b want 1", tag, MD_Stall);
      end
      lat       = 0;
      stall_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            IDEX_MdEn = 1'b0;
            s1        = $urandom;
            s2        = $urandom;
         end
         #1;
         if (MD_Valid === 1'b1) begin
            lat = k;
            break;
         end
         if (MD_Stall !== 1'b1) stall_bad++;
      end
      checks++;
      if (lat != lat_exp) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d want %0d", tag, lat, lat_exp);
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("[TB] FAIL %s calc_stall: got %0d low cycles want 0",
                  tag, stall_bad);
      end
      if (lat == 0) begin
         Mem_Hold = 1'b0;
         return;
      end
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) @(negedge clk);
         if (i == hold) Mem_Hold = 1'b0;
         #1;
         checks++;
         if (MD_Result !== exp) begin
            errors++;
            $display("[TB] FAIL %s result[%0d]: got %h want %h",
                     tag, i, MD_Result, exp);
         end
         checks++;
         if ({MD_Valid, MD_Stall, MD_Busy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL %s done_flags[%0d]: got %b want 101",
                     tag, i, {MD_Valid, MD_Stall, MD_Busy});
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({MD_Valid, MD_Busy} !== 2'b00 || MD_Result !== exp) begin
         errors++;
         $display("[TB] FAIL %s after_done: got v=%b b=%b r=%h want v=0 b=0 r=%h",
                  tag, MD_Valid, MD_Busy, MD_Result, exp);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      IDEX_MdEn = 1'b0;
      IDEX_MdOp = 3'd0;
      s1        = '0;
      s2        = '0;
      EX_Flush  = 1'b0;
      Mem_Hold  = 1'b0;
      #12;
      checks++;
      if ({MD_Stall, MD_Valid, MD_Busy} !== 3'b000 || MD_Result !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got s=%b v=%b b=%b r=%h want all 0",
                  MD_Stall, MD_Valid, MD_Busy, MD_Result);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_neg");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, "div_neg");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, "rem_neg");
      run_op(3'd5, 32'd100,       32'd7,         32'd14,        0, "divu");
      run_op(3'd7, 32'd100,       32'd7,         32'd2,         0, "remu");
   endtask

   task automatic test_special();
      run_op(3'd5, 32'd55,        32'd0,         32'hFFFF_FFFF, 0, "divu_zero");
      run_op(3'd6, 32'h0000_1234, 32'd0,         32'h0000_1234, 0, "rem_zero");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, "rem_ovf");
      run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, "divu_noovf");
   endtask

   task automatic test_flush();
      int busy_seen;
      @(negedge clk);
      IDEX_MdEn = 1'b1;
      IDEX_MdOp = 3'd0;
      s1        = 32'd1234;
      s2        = 32'd5678;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) IDEX_MdEn = 1'b0;
      end
      EX_Flush = 1'b1;
      #1;
      checks++;
      if (MD_Stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_stall: got %b want 0", MD_Stall);
      end
      busy_seen = MD_Busy;
      @(negedge clk);
      EX_Flush = 1'b0;
      #1;
      checks++;
      if ({MD_Busy, MD_Valid, MD_Stall} !== 3'b000 || busy_seen != 1) begin
         errors++;
         $display("[TB] FAIL flush_idle: got b=%b v=%b s=%b prebusy=%0d want 0 0 0 1",
                  MD_Busy, MD_Valid, MD_Stall, busy_seen);
      end
      run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, "mul_after_flush");
   endtask

   task automatic test_mem_hold();
      run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678,
             ref_result(3'd0, 32'hDEAD_BEEF, 32'h1234_5678), 3, "hold_mul");
      run_op(3'd4, 32'd77, 32'd0, 32'hFFFF_FFFF, 2, "hold_divzero");
   endtask

   task automatic test_reset_mid_calc();
      @(negedge clk);
      IDEX_MdEn = 1'b1;
      IDEX_MdOp = 3'd5;
      s1        = 32'hFFFF_0000;
      s2        = 32'd3;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) IDEX_MdEn = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({MD_Stall, MD_Valid, MD_Busy} !== 3'b000 || MD_Result !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_calc: got s=%b v=%b b=%b r=%h want all 0",
                  MD_Stall, MD_Valid, MD_Busy, MD_Result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (MD_Busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_idle: got busy=%b want 0", MD_Busy);
      end
      run_op(3'd7, 32'd1000, 32'd33, 32'd10, 0, "remu_after_reset");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          kind;
      for (int n = 0; n < 30; n++) begin
         op   = 3'($urandom_range(0, 7));
         kind = $urandom_range(0, 5);
         a    = $urandom;
         b    = $urandom;
         if (kind == 0) b = 32'd0;
         else if (kind == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (kind == 2) begin
            a = 32'($signed(32'($urandom_range(0, 200))) - 100);
            b = 32'($signed(32'($urandom_range(1, 20))) - 10);
         end
         run_op(op, a, b, ref_result(op, a, b), $urandom_range(0, 2),
                $sformatf("rand%0d_op%0d", n, op));
      end
   endtask

   task automatic test_back_to_back();
      run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 0, "b2b_mulh");
      run_op(3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0, "b2b_divu");
      run_op(3'd7, 32'd5,         32'd0,         32'd5,         0, "b2b_remu0");
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         0, "b2b_mul");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_flush();
      test_mem_hold();
      test_reset_mid_calc();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
